// File: rtl/game_countdown_timer.sv
// Round countdown timer: prescaled seconds count, BCD digits, expiry pulse.
// Optional macro GAME_TIMER_WARN_BLINK_EN gates warn with a 1 Hz blink phase.
module game_countdown_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int GAME_SEC = 30,
  parameter int WARN_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       restart,
  input  logic       play_en,
  output logic       time_over,
  output logic       expired,
  output logic [6:0] time_left,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       warn
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0] T_INIT = 7'(GAME_SEC);
  localparam logic [6:0] T_WARN = 7'(WARN_SEC);
  localparam logic [3:0] TENS_INIT = 4'(GAME_SEC / 10);
  localparam logic [3:0] ONES_INIT = 4'(GAME_SEC % 10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [6:0]    tl_n;
  logic [3:0]    tens_n, ones_n;
  logic          exp_n, tov_n;
  logic          step;
  logic          warn_base;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      presc     <= '0;
      time_left <= T_INIT;
      sec_tens  <= TENS_INIT;
      sec_ones  <= ONES_INIT;
      expired   <= 1'b0;
      time_over <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      time_left <= tl_n;
      sec_tens  <= tens_n;
      sec_ones  <= ones_n;
      expired   <= exp_n;
      time_over <= tov_n;
    end
  end

  // Next state: reload on restart/start, else prescaled countdown
  always_comb begin
    state_n = state;
    presc_n = presc;
    tl_n    = time_left;
    tens_n  = sec_tens;
    ones_n  = sec_ones;
    exp_n   = expired;
    tov_n   = 1'b0;
    step    = 1'b0;
    if (restart || start) begin
      state_n = restart ? S_IDLE : S_LOADED;
      presc_n = '0;
      tl_n    = T_INIT;
      tens_n  = TENS_INIT;
      ones_n  = ONES_INIT;
      exp_n   = 1'b0;
    end else begin
      unique case (state)
        S_LOADED: begin
          if (play_en) begin
            state_n = S_RUN;
            step    = 1'b1;
          end
        end
        S_RUN: begin
          if (play_en) step = 1'b1;
          else state_n = S_PAUSE;
        end
        S_PAUSE: begin
          if (play_en) begin
            state_n = S_RUN;
            step    = 1'b1;
          end
        end
        default: ;
      endcase
      if (step) begin
        if (presc == P_MAX) begin
          presc_n = '0;
          if (time_left != 7'd0) begin
            tl_n = time_left - 7'd1;
            if (sec_ones == 4'd0) begin
              ones_n = 4'd9;
              tens_n = sec_tens - 4'd1;
            end else begin
              ones_n = sec_ones - 4'd1;
            end
          end
          if (time_left == 7'd1) begin
            tov_n   = 1'b1;
            exp_n   = 1'b1;
            state_n = S_EXPIRED;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
    end
  end

  // Status decode from registered state
  always_comb begin
    running   = (state == S_RUN);
    warn_base = (state == S_RUN || state == S_PAUSE) &&
                (time_left != 7'd0) && (time_left <= T_WARN);
`ifdef GAME_TIMER_WARN_BLINK_EN
    warn = warn_base && (presc < PW'(TICK_DIV / 2));
`else
    warn = warn_base;
`endif
  end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer (TICK_DIV=10, GAME_SEC=3/12).
// Covers reset, countdown, pause, BCD borrow, restart and async reset.
module tb_game_countdown_timer;

`ifdef GAME_TIMER_WARN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       restart = 1'b0;
  logic       play_en = 1'b0;
  logic       time_over, expired, running, warn;
  logic [6:0] time_left;
  logic [3:0] sec_tens, sec_ones;
  logic       time_over12, expired12, running12, warn12;
  logic [6:0] time_left12;
  logic [3:0] sec_tens12, sec_ones12;

  int n_run = 0;
  int n_fail = 0;

  game_countdown_timer #(.TICK_DIV(10), .GAME_SEC(3), .WARN_SEC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .restart(restart),
    .play_en(play_en), .time_over(time_over), .expired(expired),
    .time_left(time_left), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .warn(warn)
  );

  game_countdown_timer #(.TICK_DIV(10), .GAME_SEC(12), .WARN_SEC(5)) dut12 (
    .clk(clk), .rst(rst), .start(start), .restart(restart),
    .play_en(play_en), .time_over(time_over12), .expired(expired12),
    .time_left(time_left12), .sec_tens(sec_tens12), .sec_ones(sec_ones12),
    .running(running12), .warn(warn12)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    n_run++;
    if (time_left !== 7'd3) begin
      n_fail++; $display("FAIL rst_tl: got %0d want 3", time_left);
    end
    n_run++;
    if (sec_tens !== 4'd0 || sec_ones !== 4'd3) begin
      n_fail++; $display("FAIL rst_bcd: got %0d/%0d want 0/3", sec_tens, sec_ones);
    end
    n_run++;
    if ({time_over, expired, running, warn} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_flags: got %b want 0000",
                         {time_over, expired, running, warn});
    end
    for (int i = 0; i < 6; i++) begin
      play_en = ~play_en;
      step(3);
    end
    play_en = 1'b0;
    n_run++;
    if (time_left !== 7'd3 || running !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: tl %0d run %b want 3 0", time_left, running);
    end
  endtask

  task automatic test_countdown();
    int bad_tl = 0;
    int pulses = 0;
    int pulse_at = -1;
    logic r1, w1, w10, w15, w20;
    r1 = 1'b0; w1 = 1'b0; w10 = 1'b0; w15 = 1'b0; w20 = 1'b0;
    play_en = 1'b0;
    pulse_start();
    n_run++;
    if (running !== 1'b0 || time_left !== 7'd3) begin
      n_fail++; $display("FAIL loaded: run %b tl %0d want 0 3", running, time_left);
    end
    play_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (time_left !== 7'(3 - k / 10)) bad_tl++;
      if (time_over === 1'b1) begin
        pulses++;
        pulse_at = k;
      end
      if (k == 1) begin r1 = running; w1 = warn; end
      if (k == 10) w10 = warn;
      if (k == 15) w15 = warn;
      if (k == 20) w20 = warn;
    end
    n_run++;
    if (bad_tl != 0) begin
      n_fail++; $display("FAIL cd_tl_seq: %0d bad cycles want 0", bad_tl);
    end
    n_run++;
    if (pulses != 1 || pulse_at != 30) begin
      n_fail++; $display("FAIL cd_pulse: %0d pulses at %0d want 1 at 30", pulses, pulse_at);
    end
    n_run++;
    if (r1 !== 1'b1) begin
      n_fail++; $display("FAIL cd_running: got %b want 1", r1);
    end
    n_run++;
    if (w1 !== 1'b0 || w10 !== 1'b1 || w15 !== !BLINK || w20 !== 1'b1) begin
      n_fail++; $display("FAIL cd_warn: got %b%b%b%b want 01%b1", w1, w10, w15, w20, !BLINK);
    end
    n_run++;
    if (expired !== 1'b1 || running !== 1'b0 || warn !== 1'b0) begin
      n_fail++; $display("FAIL cd_expired: exp %b run %b warn %b want 1 0 0",
                         expired, running, warn);
    end
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (time_over === 1'b1) pulses++;
    end
    n_run++;
    if (pulses != 0 || time_left !== 7'd0 || expired !== 1'b1) begin
      n_fail++; $display("FAIL cd_hold: pulses %0d tl %0d exp %b want 0 0 1",
                         pulses, time_left, expired);
    end
    play_en = 1'b0;
  endtask

  task automatic test_pause();
    play_en = 1'b0;
    pulse_start();
    play_en = 1'b1;
    step(15);
    n_run++;
    if (time_left !== 7'd2) begin
      n_fail++; $display("FAIL ps_pre: tl %0d want 2", time_left);
    end
    play_en = 1'b0;
    step(40);
    n_run++;
    if (time_left !== 7'd2 || running !== 1'b0 || warn !== !BLINK) begin
      n_fail++; $display("FAIL ps_hold: tl %0d run %b warn %b want 2 0 %b",
                         time_left, running, warn, !BLINK);
    end
    play_en = 1'b1;
    step(4);
    n_run++;
    if (time_left !== 7'd2) begin
      n_fail++; $display("FAIL ps_resume4: tl %0d want 2", time_left);
    end
    step(1);
    n_run++;
    if (time_left !== 7'd1) begin
      n_fail++; $display("FAIL ps_resume5: tl %0d want 1", time_left);
    end
    play_en = 1'b0;
  endtask

  task automatic test_bcd();
    play_en = 1'b0;
    pulse_start();
    n_run++;
    if (sec_tens12 !== 4'd1 || sec_ones12 !== 4'd2) begin
      n_fail++; $display("FAIL bcd_12: got %0d/%0d want 1/2", sec_tens12, sec_ones12);
    end
    play_en = 1'b1;
    step(10);
    n_run++;
    if (sec_tens12 !== 4'd1 || sec_ones12 !== 4'd1) begin
      n_fail++; $display("FAIL bcd_11: got %0d/%0d want 1/1", sec_tens12, sec_ones12);
    end
    step(10);
    n_run++;
    if (sec_tens12 !== 4'd1 || sec_ones12 !== 4'd0) begin
      n_fail++; $display("FAIL bcd_10: got %0d/%0d want 1/0", sec_tens12, sec_ones12);
    end
    step(10);
    n_run++;
    if (sec_tens12 !== 4'd0 || sec_ones12 !== 4'd9 || time_left12 !== 7'd9) begin
      n_fail++; $display("FAIL bcd_09: got %0d/%0d tl %0d want 0/9 9",
                         sec_tens12, sec_ones12, time_left12);
    end
    play_en = 1'b0;
  endtask

  task automatic test_restart();
    play_en = 1'b0;
    pulse_start();
    play_en = 1'b1;
    step(20);
    n_run++;
    if (time_left !== 7'd1 || running !== 1'b1) begin
      n_fail++; $display("FAIL rs_pre: tl %0d run %b want 1 1", time_left, running);
    end
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    n_run++;
    if (time_left !== 7'd3 || running !== 1'b0 || expired !== 1'b0 || time_over !== 1'b0) begin
      n_fail++; $display("FAIL rs_reload: tl %0d run %b exp %b tov %b want 3 0 0 0",
                         time_left, running, expired, time_over);
    end
    step(5);
    n_run++;
    if (time_left !== 7'd3 || running !== 1'b0) begin
      n_fail++; $display("FAIL rs_idle: tl %0d run %b want 3 0", time_left, running);
    end
    play_en = 1'b0;
    pulse_start();
    play_en = 1'b1;
    step(1);
    n_run++;
    if (running !== 1'b1) begin
      n_fail++; $display("FAIL rs_loaded_run: run %b want 1", running);
    end
    play_en = 1'b0;
    pulse_start();
    play_en = 1'b1;
    step(29);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    n_run++;
    if (time_over !== 1'b0 || time_left !== 7'd3 || expired !== 1'b0) begin
      n_fail++; $display("FAIL rs_edge_restart: tov %b tl %0d exp %b want 0 3 0",
                         time_over, time_left, expired);
    end
    play_en = 1'b0;
    pulse_start();
    play_en = 1'b1;
    step(29);
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_run++;
    if (time_over !== 1'b0 || time_left !== 7'd3 || running !== 1'b0) begin
      n_fail++; $display("FAIL rs_edge_start: tov %b tl %0d run %b want 0 3 0",
                         time_over, time_left, running);
    end
    play_en = 1'b0;
  endtask

  task automatic test_async_reset();
    play_en = 1'b0;
    pulse_start();
    play_en = 1'b1;
    step(12);
    n_run++;
    if (time_left !== 7'd2 || running !== 1'b1 || warn !== 1'b1) begin
      n_fail++; $display("FAIL ar_pre: tl %0d run %b warn %b want 2 1 1",
                         time_left, running, warn);
    end
    #2;
    rst = 1'b1;
    #1;
    n_run++;
    if (time_left !== 7'd3 || sec_tens !== 4'd0 || sec_ones !== 4'd3) begin
      n_fail++; $display("FAIL ar_tl: tl %0d bcd %0d/%0d want 3 0/3",
                         time_left, sec_tens, sec_ones);
    end
    n_run++;
    if ({time_over, expired, running, warn} !== 4'b0000) begin
      n_fail++; $display("FAIL ar_flags: got %b want 0000",
                         {time_over, expired, running, warn});
    end
    #2;
    rst = 1'b0;
    play_en = 1'b0;
    step(2);
    n_run++;
    if (time_left !== 7'd3 || running !== 1'b0) begin
      n_fail++; $display("FAIL ar_after: tl %0d run %b want 3 0", time_left, running);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_bcd();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
